// File: rtl/shift_counter_pkg.sv
// Shared encodings for the ring / Johnson shift counter.
// Mode selects the sequence family; dir selects the shift direction.
// Nothing here holds state.
package shift_counter_pkg;

    typedef enum logic {
        MODE_RING    = 1'b0,
        MODE_JOHNSON = 1'b1
    } mode_e;

    // Shift direction encodings as seen on the dir input.
    localparam logic DIR_LSB = 1'b0;
    localparam logic DIR_MSB = 1'b1;

endpackage

// File: rtl/shift_counter_decode.sv
// Decodes a pattern into legality and step index for ring or Johnson mode.
// Latency: purely combinational.
// Backpressure: none; pure function of its inputs.
module shift_counter_decode
    import shift_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int PW   = $clog2(2*WIDTH)
) (
    input  logic [WIDTH-1:0] pattern,
    input  logic             mode,
    output logic             legal,
    output logic [PW-1:0]    phase
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [PW-1:0]    pop;
    logic [PW-1:0]    ring_pos;
    logic [WIDTH-1:0] inv;
    logic             ring_ok;
    logic             john_ok;

    // Population count, set-bit position from MSB, and shape tests.
    // A pattern of the form 0..01..1 satisfies p & (p+1) == 0; the MSB-anchored
    // form 1..10..0 is the same test on the inverted pattern.
    always_comb begin
        pop      = '0;
        ring_pos = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + PW'(pattern[i]);
            if (pattern[i]) begin
                ring_pos = PW'(WIDTH - 1 - i);
            end
        end
        inv     = ~pattern;
        ring_ok = (pop == PW'(1));
        john_ok = ((pattern & (pattern + ONE)) == '0) || ((inv & (inv + ONE)) == '0);
        if (mode == MODE_JOHNSON) begin
            legal = john_ok;
            phase = pattern[WIDTH-1] ? (pop - PW'(1)) : (PW'(2*WIDTH - 1) - pop);
        end else begin
            legal = ring_ok;
            phase = ring_pos;
        end
    end

endmodule

// File: rtl/shift_counter_gen.sv
// Ring / Johnson shift counter with load, direction control and self-correction.
// Latency: q, wrap and illegal update one clock after the controlling inputs.
// Backpressure: none; en gates stepping, the counter is always ready.
module shift_counter_gen
    import shift_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int PW   = $clog2(2*WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [PW-1:0]    phase,
    output logic             wrap,
    output logic             illegal
);

    // Single MSB set: phase 0 in both ring and Johnson sequences.
    localparam logic [WIDTH-1:0] RESET_PAT = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] q_r;
    logic             mode_q;
    logic             wrap_r;
    logic             illegal_r;

    logic [WIDTH-1:0] q_nxt;
    logic             wrap_nxt;
    logic             illegal_nxt;
    logic             fb;
    logic [WIDTH-1:0] step;
    logic [PW-1:0]    last_phase;

    logic             q_legal;
    logic [PW-1:0]    q_phase;
    logic             ld_legal;
    logic [PW-1:0]    ld_phase_unused;

    // Current state is judged against the mode it was built under.
    shift_counter_decode #(.WIDTH(WIDTH)) u_q_dec (
        .pattern (q_r),
        .mode    (mode_q),
        .legal   (q_legal),
        .phase   (q_phase)
    );

    // A loaded pattern must fit the mode that will be in force after the edge.
    shift_counter_decode #(.WIDTH(WIDTH)) u_ld_dec (
        .pattern (load_val),
        .mode    (mode),
        .legal   (ld_legal),
        .phase   (ld_phase_unused)
    );

    // Next state: load beats mode change beats correction beats step beats hold.
    always_comb begin
        q_nxt       = q_r;
        wrap_nxt    = 1'b0;
        illegal_nxt = 1'b0;
        fb          = (dir == DIR_MSB) ? q_r[WIDTH-1] : q_r[0];
        if (mode_q == MODE_JOHNSON) begin
            fb = ~fb;
        end
        step        = (dir == DIR_MSB) ? {q_r[WIDTH-2:0], fb} : {fb, q_r[WIDTH-1:1]};
        last_phase  = (mode_q == MODE_JOHNSON) ? PW'(2*WIDTH - 1) : PW'(WIDTH - 1);
        if (load) begin
            if (ld_legal) begin
                q_nxt = load_val;
            end else begin
                q_nxt       = RESET_PAT;
                illegal_nxt = 1'b1;
            end
        end else if (mode != mode_q) begin
            q_nxt = RESET_PAT;
        end else if (!q_legal) begin
            q_nxt       = RESET_PAT;
            illegal_nxt = 1'b1;
        end else if (en) begin
            q_nxt    = step;
            wrap_nxt = (dir == DIR_MSB) ? (q_phase == '0) : (q_phase == last_phase);
        end
    end

    // State and pulse registers; mode is sampled every edge to detect changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r       <= RESET_PAT;
            mode_q    <= MODE_RING;
            wrap_r    <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            q_r       <= q_nxt;
            mode_q    <= mode;
            wrap_r    <= wrap_nxt;
            illegal_r <= illegal_nxt;
        end
    end

    assign q       = q_r;
    assign qbar    = ~q_r;
    assign phase   = q_phase;
    assign wrap    = wrap_r;
    assign illegal = illegal_r;

endmodule

// File: tb/tb_shift_counter_gen.sv
// Randomized bench for shift_counter_gen with a phase-index reference model.
// The model tracks the step index and derives the pattern from it.
// Directed sequences pin the model with literal expectations.
module tb_shift_counter_gen;

    localparam int W  = 4;
    localparam int PW = 3;

    logic          clk;
    logic          rst;
    logic          en;
    logic          mode;
    logic          dir;
    logic          load;
    logic [W-1:0]  load_val;
    logic [W-1:0]  q;
    logic [W-1:0]  qbar;
    logic [PW-1:0] phase;
    logic          wrap;
    logic          illegal;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 0;

    // Reference model state: mode in force, step index, pulse flags,
    // and a raw pattern for externally corrupted states.
    logic         m_mq      = 1'b0;
    int           m_k       = 0;
    bit           m_wrap    = 0;
    bit           m_ill     = 0;
    bit           m_corrupt = 0;
    logic [W-1:0] m_raw     = '0;

    shift_counter_gen #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .qbar     (qbar),
        .phase    (phase),
        .wrap     (wrap),
        .illegal  (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int period(logic md);
        return md ? 2*W : W;
    endfunction

    // Pattern at step k of the sequence for mode md.
    function automatic logic [W-1:0] pat(logic md, int k);
        logic [W-1:0] r;
        r = '0;
        if (!md) begin
            r[W-1-k] = 1'b1;
        end else if (k < W) begin
            for (int i = 0; i <= k; i++) r[W-1-i] = 1'b1;
        end else begin
            for (int i = 0; i < 2*W-1-k; i++) r[i] = 1'b1;
        end
        return r;
    endfunction

    // Step index of p in mode md, or -1 when p is not in the sequence.
    function automatic int find_phase(logic md, logic [W-1:0] p);
        for (int k = 0; k < period(md); k++) begin
            if (pat(md, k) == p) return k;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model update.
    always @(posedge clk or posedge rst) begin
        int fk;
        if (rst) begin
            m_mq = 1'b0; m_k = 0; m_wrap = 0; m_ill = 0; m_corrupt = 0;
        end else begin
            m_wrap = 0;
            m_ill  = 0;
            if (load) begin
                fk = find_phase(mode, load_val);
                m_corrupt = 0;
                if (fk >= 0) m_k = fk;
                else begin m_k = 0; m_ill = 1; end
            end else if (mode != m_mq) begin
                m_k = 0;
                m_corrupt = 0;
            end else if (m_corrupt) begin
                m_k = 0;
                m_corrupt = 0;
                m_ill = 1;
            end else if (en) begin
                if (dir == 1'b0) begin
                    if (m_k == period(m_mq) - 1) m_wrap = 1;
                    m_k = (m_k + 1) % period(m_mq);
                end else begin
                    if (m_k == 0) m_wrap = 1;
                    m_k = (m_k + period(m_mq) - 1) % period(m_mq);
                end
            end
            m_mq = mode;
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        logic [W-1:0] eq;
        logic [W-1:0] eqb;
        if (chk_on) begin
            eq  = m_corrupt ? m_raw : pat(m_mq, m_k);
            eqb = ~eq;
            chk("model_q", q, eq);
            chk("model_qbar", qbar, eqb);
            if (!m_corrupt) chk("model_phase", phase, m_k);
            chk("model_wrap", wrap, m_wrap);
            chk("model_illegal", illegal, m_ill);
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    // Overwrite the state register to reach a pattern no input sequence can produce.
    task automatic poke(input logic [W-1:0] p);
        int fk;
        force dut.q_r = p;
        fk = find_phase(m_mq, p);
        if (fk >= 0) begin
            m_k = fk;
            m_corrupt = 0;
        end else begin
            m_corrupt = 1;
            m_raw = p;
        end
        #1;
        release dut.q_r;
    endtask

    logic [W-1:0] seq33 [0:8];
    logic [W-1:0] seq34 [0:4];
    logic [W-1:0] rp;

    initial begin
        seq33[0] = 4'b1000; seq33[1] = 4'b1100; seq33[2] = 4'b1110;
        seq33[3] = 4'b1111; seq33[4] = 4'b0111; seq33[5] = 4'b0011;
        seq33[6] = 4'b0001; seq33[7] = 4'b0000; seq33[8] = 4'b1000;
        seq34[0] = 4'b0001; seq34[1] = 4'b0010; seq34[2] = 4'b0100;
        seq34[3] = 4'b1000; seq34[4] = 4'b0001;

        rst = 1'b1; mode = 1'b1; dir = 1'b0; en = 1'b1; load = 1'b0; load_val = '0;
        cyc(); cyc();
        chk("rst_q", q, 4'b1000);
        chk("rst_qbar", qbar, 4'b0111);
        chk("rst_phase", phase, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_illegal", illegal, 0);
        chk_on = 1;
        rst = 1'b0;

        // Johnson forward: first edge is the mode change, then a full lap.
        for (int i = 0; i < 9; i++) begin
            cyc();
            chk("john_q", q, seq33[i]);
            chk("john_phase", phase, i % 8);
            chk("john_wrap", wrap, (i == 8) ? 1 : 0);
            chk("john_illegal", illegal, 0);
        end
        cyc(); chk("john_q9", q, 4'b1100);
        cyc(); chk("john_q10", q, 4'b1110);

        // Mode toggle mid-sequence snaps back to the start pattern.
        mode = 1'b0;
        cyc();
        chk("modechg_q", q, 4'b1000);
        chk("modechg_wrap", wrap, 0);
        chk("modechg_illegal", illegal, 0);

        // Ring toward MSB: first step from the start pattern wraps.
        dir = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("ring_q", q, seq34[i]);
            chk("ring_phase", phase, 3 - (i % 4));
            chk("ring_wrap", wrap, (i == 0 || i == 4) ? 1 : 0);
        end

        // Loads: illegal ring pattern is rejected, legal one accepted, then hold.
        en = 1'b0; load = 1'b1; load_val = 4'b0110;
        cyc();
        chk("load_bad_q", q, 4'b1000);
        chk("load_bad_illegal", illegal, 1);
        load_val = 4'b0010;
        cyc();
        chk("load_ok_q", q, 4'b0010);
        chk("load_ok_illegal", illegal, 0);
        load = 1'b0;
        cyc();
        chk("hold_q", q, 4'b0010);
        chk("hold_illegal", illegal, 0);

        // Corrupted Johnson state is corrected even with en low.
        mode = 1'b1;
        cyc();
        chk("tojohn_q", q, 4'b1000);
        poke(4'b1010);
        chk("poke_q", q, 4'b1010);
        cyc();
        chk("fix_q", q, 4'b1000);
        chk("fix_illegal", illegal, 1);
        cyc();
        chk("fix_hold_q", q, 4'b1000);
        chk("fix_hold_illegal", illegal, 0);

        // Asynchronous reset between edges at 0011.
        en = 1'b1; dir = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        chk("pre_rst_q", q, 4'b0011);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_q", q, 4'b1000);
        chk("async_rst_wrap", wrap, 0);
        chk("async_rst_illegal", illegal, 0);
        rst = 1'b0;
        cyc();
        chk("post_rst_q", q, 4'b1000);

        // Randomized traffic against the model.
        for (int n = 0; n < 800; n++) begin
            cyc();
            load     = ($urandom_range(0, 7) == 0);
            load_val = W'($urandom);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            dir      = 1'($urandom_range(0, 1));
            en       = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 23) == 0) begin
                rp = W'($urandom);
                poke(rp);
            end
            if ($urandom_range(0, 63) == 0) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
